mv_delta_loader: RTL and testbench
==================================

// Module: mv_delta_loader
// PURPOSE
//  Upstream feeder for the PMV update stage. Accepts decoded motion_code/motion_residual
//  components for one macroblock over a valid/ready handshake. Forms the sign+magnitude
//  delta word and writes it into the 8-entry delta buffer, which the update stage reads
//  as its Data_0 port. When all 8 slots are written, kicks the update stage and waits
//  for it to return to idle.
// PARAMETERS
//  NUM_SLOTS   8   delta buffer depth; slot index = {s, r, t} (s=dir, r=vector, t=h/v)
//  RES_W       8   motion_residual width (max r_size = f_code-1 = 8)
// PORTS
//  clock              in   1   system clock
//  resetn             in   1   asynchronous, active-low reset
//  Start_Load_I       in   1   1-cycle pulse: begin macroblock; sampled only in IDLE
//  Slot_Mask_I        in   8   slots present in bitstream; sampled with Start_Load_I
//  F_Codes_I          in   16  {f[0][0],f[0][1],f[1][0],f[1][1]}, 4 bits each; stable while busy
//  Comp_Valid_I       in   1   component available
//  Comp_Ready_O       out  1   component accepted when Valid & Ready
//  Code_Sign_I        in   1   motion_code sign (1 = negative)
//  Code_Mag_I         in   5   |motion_code|, legal 0..16
//  Residual_I         in   8   motion_residual; only low r_size bits used
//  Delta_Index_O      out  3   delta buffer write address
//  Delta_Data_O       out  16  [15:14]=0, [13]=sign, [12:0]=magnitude
//  Delta_Write_En_O   out  1   delta buffer write strobe
//  Start_Update_O     out  1   1-cycle kick to update stage
//  Done_Update_I      in   1   update stage idle (level)
//  Done_Load_O        out  1   high only in IDLE
//  Error_O            out  1   sticky per macroblock: illegal code or f_code
// BEHAVIOUR
//  Reset: state=IDLE, slot=0, all outputs 0 except Done_Load_O=1; Error_O cleared.
//  States: IDLE -> LOAD -> KICK -> WAIT_BUSY -> WAIT_DONE -> IDLE.
//  IDLE: on Start_Load_I, latch mask, slot<=0, Error_O<=0, go LOAD.
//  LOAD: per slot, in ascending order 0..7:
//   - mask[slot]=1: Comp_Ready_O=1 (combinational from state/mask). On Valid&Ready,
//     register the write (Delta_Write_En_O=1, index=slot) next cycle; slot++.
//   - mask[slot]=0: write 16'h0000 to slot next cycle without handshake; slot++.
//   - One slot per cycle max. After slot 7 write issued, go KICK.
//  f_code for slot i = F_Codes_I nibble {i[2],i[0]}: 00->[15:12], 01->[11:8],
//   10->[7:4], 11->[3:0]. r_size = f_code-1.
//  Magnitude: Code_Mag_I==0 -> 0, sign forced 0.
//   Else ((Code_Mag_I-1)<<r_size) + (Residual_I & ((1<<r_size)-1)) + 1.
//   Max 15<<8+255+1 = 4096, fits 13 bits.
//  Errors (set Error_O, still write): Code_Mag_I>16 -> write 0 delta;
//   f_code 0 or >9 -> r_size forced 0.
//  KICK: Start_Update_O=1 one cycle -> WAIT_BUSY.
//  WAIT_BUSY: wait for Done_Update_I=0; timeout: after 2 cycles still high -> treat as done.
//  WAIT_DONE: on Done_Update_I=1 -> IDLE.
//  Start_Load_I outside IDLE ignored. Valid without Ready: producer holds data.
//   Ready never asserted for masked-off slots or outside LOAD.
//  Reset mid-operation: immediate return to IDLE; partial buffer contents undefined;
//   no Start_Update_O issued.
// TESTING
//  1. mask=8'h01, f_code all 1, comp (+,mag=1,res=x) -> slot0 data 16'h0001;
//     slots1-7 = 0; one Start_Update_O.
//  2. f[0][0]=3, (-,mag=3,res=2) -> mag ((2<<2)+2+1)=11, data 16'h200B.
//  3. f=9, (+,16,255) -> magnitude 4096 (16'h1000); no error.
//  4. Code_Mag_I=17 -> slot written 0, Error_O=1; Error_O clears on next start.
//  5. mask=8'hFF, Valid low 3 cycles between components -> no write gaps mis-indexed;
//     Start_Load_I during LOAD ignored.
//  6. resetn low during LOAD at slot 4 -> outputs to reset values; new start works.

Source files
------------

// File: rtl/mv_delta_loader_if.sv
// Component handshake between the motion-vector decoder (producer) and the
// delta loader (consumer). The producer holds its fields stable while Valid is
// high and Ready is low.
//   Comp_Valid_I   producer -> loader  component available
//   Comp_Ready_O   loader -> producer  component accepted on Valid & Ready
//   Code_Sign_I    producer -> loader  motion_code sign (1 = negative)
//   Code_Mag_I     producer -> loader  |motion_code|, legal 0..16
//   Residual_I     producer -> loader  motion_residual
interface mv_delta_loader_if #(
    parameter int RES_W = 8
);
    logic             Comp_Valid_I;
    logic             Comp_Ready_O;
    logic             Code_Sign_I;
    logic [4:0]       Code_Mag_I;
    logic [RES_W-1:0] Residual_I;

    modport master (
        output Comp_Valid_I, Code_Sign_I, Code_Mag_I, Residual_I,
        input  Comp_Ready_O
    );

    modport slave (
        input  Comp_Valid_I, Code_Sign_I, Code_Mag_I, Residual_I,
        output Comp_Ready_O
    );
endinterface

// File: rtl/mv_delta_loader.sv
// mv_delta_loader: feeds the PMV update stage. Takes one macroblock's decoded
// motion_code/motion_residual components, forms sign+magnitude delta words and
// writes all 8 delta buffer slots in order, then kicks the update stage and
// waits for it to go busy and return to idle.
//   clock, resetn       clock, asynchronous active-low reset
//   Start_Load_I        begin macroblock (IDLE only), Slot_Mask_I latched with it
//   F_Codes_I           {f00,f01,f10,f11} nibbles, stable while busy
//   comp                component handshake (slave side)
//   Delta_Index_O/Data_O/Write_En_O   registered delta buffer write port
//   Start_Update_O      one-cycle kick, Done_Update_I update stage idle level
//   Done_Load_O         high only in IDLE, Error_O sticky per macroblock
module mv_delta_loader #(
    parameter int NUM_SLOTS = 8,
    parameter int RES_W     = 8
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 Start_Load_I,
    input  logic [NUM_SLOTS-1:0] Slot_Mask_I,
    input  logic [15:0]          F_Codes_I,
    mv_delta_loader_if.slave     comp,
    output logic [2:0]           Delta_Index_O,
    output logic [15:0]          Delta_Data_O,
    output logic                 Delta_Write_En_O,
    output logic                 Start_Update_O,
    input  logic                 Done_Update_I,
    output logic                 Done_Load_O,
    output logic                 Error_O
);
    typedef enum logic [2:0] {IDLE, LOAD, KICK, WAIT_BUSY, WAIT_DONE} state_t;

    state_t               r_state;
    logic [2:0]           r_slot;
    logic [NUM_SLOTS-1:0] r_mask;
    logic [2:0]           r_idx;
    logic [15:0]          r_data;
    logic                 r_we;
    logic                 r_start;
    logic                 r_done;
    logic                 r_err;
    logic                 r_wait;

    logic        w_present;
    logic        w_ready;
    logic        w_fire;
    logic [3:0]  w_fcode;
    logic        w_f_bad;
    logic        w_mag_bad;
    logic [3:0]  w_rsize;
    logic [12:0] w_hi;
    logic [12:0] w_res;
    logic [12:0] w_mag;
    logic [15:0] w_data;

    assign w_present         = r_mask[r_slot];
    assign w_ready           = (r_state == LOAD) && w_present;
    assign w_fire            = w_ready && comp.Comp_Valid_I;
    assign comp.Comp_Ready_O = w_ready;

    // Slot index is {dir, vector, h/v}; f_code depends on dir and h/v only.
    always_comb begin
        w_fcode = F_Codes_I[15:12];
        case ({r_slot[2], r_slot[0]})
            2'b00:   w_fcode = F_Codes_I[15:12];
            2'b01:   w_fcode = F_Codes_I[11:8];
            2'b10:   w_fcode = F_Codes_I[7:4];
            default: w_fcode = F_Codes_I[3:0];
        endcase
    end

    // Illegal f_code still writes, with r_size collapsed to 0.
    assign w_f_bad   = (w_fcode == 4'd0) || (w_fcode > 4'd9);
    assign w_rsize   = w_f_bad ? 4'd0 : (w_fcode - 4'd1);
    assign w_mag_bad = comp.Code_Mag_I > 5'd16;

    // Only meaningful for Code_Mag_I in 1..16, so (mag-1) never underflows here.
    assign w_hi  = 13'(comp.Code_Mag_I - 5'd1) << w_rsize;
    assign w_res = 13'(comp.Residual_I) & ((13'd1 << w_rsize) - 13'd1);
    assign w_mag = w_hi + w_res + 13'd1;

    always_comb begin
        w_data = 16'h0000;
        if (!w_mag_bad && comp.Code_Mag_I != 5'd0)
            w_data = {2'b00, comp.Code_Sign_I, w_mag};
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_slot  <= '0;
            r_mask  <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_we    <= 1'b0;
            r_start <= 1'b0;
            r_done  <= 1'b1;
            r_err   <= 1'b0;
            r_wait  <= 1'b0;
        end else begin
            r_we    <= 1'b0;
            r_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (Start_Load_I) begin
                        r_mask  <= Slot_Mask_I;
                        r_slot  <= '0;
                        r_err   <= 1'b0;
                        r_done  <= 1'b0;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    // Absent slots are zero-filled without waiting for the producer.
                    if (!w_present || w_fire) begin
                        r_we   <= 1'b1;
                        r_idx  <= r_slot;
                        r_data <= w_present ? w_data : 16'h0000;
                        if (w_present && (w_mag_bad || w_f_bad))
                            r_err <= 1'b1;
                        r_slot <= r_slot + 3'd1;
                        if (r_slot == 3'd7)
                            r_state <= KICK;
                    end
                end
                KICK: begin
                    // Slot 7's write is on the bus this cycle; kick follows it.
                    r_start <= 1'b1;
                    r_wait  <= 1'b0;
                    r_state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // An update stage that never drops Done within 2 cycles is
                    // assumed to have finished already.
                    if (!Done_Update_I) begin
                        r_state <= WAIT_DONE;
                    end else if (r_wait) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end else begin
                        r_wait <= 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (Done_Update_I) begin
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_done  <= 1'b1;
                end
            endcase
        end
    end

    assign Delta_Index_O    = r_idx;
    assign Delta_Data_O     = r_data;
    assign Delta_Write_En_O = r_we;
    assign Start_Update_O   = r_start;
    assign Done_Load_O      = r_done;
    assign Error_O          = r_err;
endmodule

// File: tb/tb_mv_delta_loader.sv
module tb_mv_delta_loader;
    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        Start_Load_I = 1'b0;
    logic [7:0]  Slot_Mask_I = '0;
    logic [15:0] F_Codes_I = 16'h1111;
    logic [2:0]  Delta_Index_O;
    logic [15:0] Delta_Data_O;
    logic        Delta_Write_En_O;
    logic        Start_Update_O;
    logic        Done_Update_I = 1'b1;
    logic        Done_Load_O;
    logic        Error_O;

    mv_delta_loader_if cif ();

    mv_delta_loader dut (
        .clock            (clock),
        .resetn           (resetn),
        .Start_Load_I     (Start_Load_I),
        .Slot_Mask_I      (Slot_Mask_I),
        .F_Codes_I        (F_Codes_I),
        .comp             (cif.slave),
        .Delta_Index_O    (Delta_Index_O),
        .Delta_Data_O     (Delta_Data_O),
        .Delta_Write_En_O (Delta_Write_En_O),
        .Start_Update_O   (Start_Update_O),
        .Done_Update_I    (Done_Update_I),
        .Done_Load_O      (Done_Load_O),
        .Error_O          (Error_O)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0]  idx;
        logic [15:0] data;
    } wr_t;

    wr_t         q[$];
    wr_t         m_e;
    int          m_run = 0, m_fail = 0, kicks = 0;
    int          n_run = 0, n_fail = 0;
    logic [15:0] exp_d [8];
    logic        stub_en = 1'b1;
    int          stub_cnt = 0;

    // Update stage stand-in: goes busy for 3 cycles after each kick.
    always @(posedge clock) begin
        if (!stub_en) begin
            Done_Update_I <= 1'b1;
        end else if (Start_Update_O) begin
            stub_cnt      <= 3;
            Done_Update_I <= 1'b0;
        end else if (stub_cnt > 1) begin
            stub_cnt <= stub_cnt - 1;
        end else begin
            stub_cnt      <= 0;
            Done_Update_I <= 1'b1;
        end
    end

    // Scoreboard monitor: every write strobe must match the next expected slot.
    always @(negedge clock) begin
        if (resetn && Delta_Write_En_O) begin
            m_run++;
            if (q.size() == 0) begin
                m_fail++;
                $display("FAIL write_unexpected: got idx=%0d data=%h, expected none", Delta_Index_O, Delta_Data_O);
            end else begin
                m_e = q.pop_front();
                if (Delta_Index_O !== m_e.idx || Delta_Data_O !== m_e.data) begin
                    m_fail++;
                    $display("FAIL write_slot: got idx=%0d data=%h, expected idx=%0d data=%h",
                             Delta_Index_O, Delta_Data_O, m_e.idx, m_e.data);
                end
            end
        end
        if (resetn && Start_Update_O) kicks++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_run++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    task automatic start_mb(input logic [7:0] mask, input logic [15:0] f);
        for (int i = 0; i < 8; i++) q.push_back({3'(i), exp_d[i]});
        @(negedge clock);
        F_Codes_I    = f;
        Slot_Mask_I  = mask;
        Start_Load_I = 1'b1;
        @(negedge clock);
        Start_Load_I = 1'b0;
        Slot_Mask_I  = '0;
    endtask

    task automatic send(input logic s, input logic [4:0] m, input logic [7:0] r);
        int n;
        cif.Comp_Valid_I = 1'b1;
        cif.Code_Sign_I  = s;
        cif.Code_Mag_I   = m;
        cif.Residual_I   = r;
        n = 0;
        while (!cif.Comp_Ready_O && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) begin
            n_run++;
            n_fail++;
            $display("FAIL ready_timeout: got no ready, expected ready within 50 cycles");
        end
        @(negedge clock);
        cif.Comp_Valid_I = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!Done_Load_O && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk(name, {31'd0, Done_Load_O}, 32'd1);
        repeat (2) @(negedge clock);
    endtask

    task automatic zero_exp();
        for (int i = 0; i < 8; i++) exp_d[i] = 16'h0000;
    endtask

    int k0;

    initial begin
        cif.Comp_Valid_I = 1'b0;
        cif.Code_Sign_I  = 1'b0;
        cif.Code_Mag_I   = '0;
        cif.Residual_I   = '0;
        repeat (2) @(negedge clock);
        chk("reset_done_load", {31'd0, Done_Load_O}, 32'd1);
        chk("reset_outputs", {28'd0, Delta_Write_En_O, Start_Update_O, Error_O, cif.Comp_Ready_O}, 32'd0);
        resetn = 1'b1;
        @(negedge clock);

        // 1: single present slot, f_code 1
        zero_exp(); exp_d[0] = 16'h0001; k0 = kicks;
        start_mb(8'h01, 16'h1111);
        chk("t1_busy", {31'd0, Done_Load_O}, 32'd0);
        send(1'b0, 5'd1, 8'hA5);
        wait_idle("t1_idle");
        chk("t1_kick", kicks - k0, 1);
        chk("t1_err", {31'd0, Error_O}, 32'd0);

        // 2: f[0][0]=3, negative
        zero_exp(); exp_d[0] = 16'h200B; k0 = kicks;
        start_mb(8'h01, 16'h3111);
        send(1'b1, 5'd3, 8'd2);
        wait_idle("t2_idle");
        chk("t2_kick", kicks - k0, 1);

        // 3: max magnitude; update stage never drops Done (timeout path)
        stub_en = 1'b0;
        zero_exp(); exp_d[0] = 16'h1000; k0 = kicks;
        start_mb(8'h01, 16'h9111);
        send(1'b0, 5'd16, 8'd255);
        wait_idle("t3_timeout_idle");
        chk("t3_kick", kicks - k0, 1);
        chk("t3_err", {31'd0, Error_O}, 32'd0);
        stub_en = 1'b1;

        // 4: illegal magnitude -> zero write, sticky error
        zero_exp();
        start_mb(8'h01, 16'h1111);
        send(1'b0, 5'd17, 8'd3);
        wait_idle("t4_idle");
        chk("t4_err_set", {31'd0, Error_O}, 32'd1);

        // 4b: illegal f_code 0 -> r_size 0, error; start clears previous error
        zero_exp(); exp_d[0] = 16'h0002;
        start_mb(8'h01, 16'h0111);
        chk("t4_err_cleared", {31'd0, Error_O}, 32'd0);
        send(1'b0, 5'd2, 8'd1);
        wait_idle("t4b_idle");
        chk("t4b_err_fcode", {31'd0, Error_O}, 32'd1);

        // 5: all slots, f = {2,3,4,5}, gaps, stray start mid-load
        exp_d = '{16'h0004, 16'h2004, 16'h0000, 16'h0010,
                  16'h200E, 16'h0100, 16'h0008, 16'h2021};
        k0 = kicks;
        start_mb(8'hFF, 16'h2345);
        chk("t5_err_cleared", {31'd0, Error_O}, 32'd0);
        send(1'b0, 5'd2, 8'd1);
        Start_Load_I = 1'b1; Slot_Mask_I = 8'h00;
        @(negedge clock);
        Start_Load_I = 1'b0;
        repeat (2) @(negedge clock);
        send(1'b1, 5'd1, 8'd3);   repeat (3) @(negedge clock);
        send(1'b1, 5'd0, 8'd1);   repeat (3) @(negedge clock);
        send(1'b0, 5'd4, 8'd7);   repeat (3) @(negedge clock);
        send(1'b1, 5'd2, 8'd5);   repeat (3) @(negedge clock);
        send(1'b0, 5'd16, 8'd15); repeat (3) @(negedge clock);
        send(1'b0, 5'd1, 8'd255); repeat (3) @(negedge clock);
        send(1'b1, 5'd3, 8'd16);
        wait_idle("t5_idle");
        chk("t5_kick", kicks - k0, 1);
        chk("t5_err", {31'd0, Error_O}, 32'd0);

        // 6: reset in the middle of LOAD at slot 4
        exp_d = '{16'h0001, 16'h0001, 16'h0001, 16'h0001,
                  16'h0000, 16'h0000, 16'h0000, 16'h0000};
        k0 = kicks;
        for (int i = 0; i < 4; i++) q.push_back({3'(i), exp_d[i]});
        @(negedge clock);
        F_Codes_I = 16'h1111; Slot_Mask_I = 8'hFF; Start_Load_I = 1'b1;
        @(negedge clock);
        Start_Load_I = 1'b0;
        for (int i = 0; i < 4; i++) send(1'b0, 5'd1, 8'd0);
        repeat (2) @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        chk("t6_reset_done_load", {31'd0, Done_Load_O}, 32'd1);
        chk("t6_reset_outputs", {28'd0, Delta_Write_En_O, Start_Update_O, Error_O, cif.Comp_Ready_O}, 32'd0);
        resetn = 1'b1;
        repeat (4) @(negedge clock);
        chk("t6_no_kick", kicks - k0, 0);
        chk("t6_queue_drained", q.size(), 0);

        zero_exp(); exp_d[0] = 16'h0001; k0 = kicks;
        start_mb(8'h01, 16'h1111);
        send(1'b0, 5'd1, 8'd0);
        wait_idle("t6_restart_idle");
        chk("t6_restart_kick", kicks - k0, 1);
        chk("end_queue_drained", q.size(), 0);

        n_run  += m_run;
        n_fail += m_fail;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish before 500us");
        $fatal(1, "timeout");
    end
endmodule
